// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch program-counter generator.
// Holds the FSM state encodings, the redirect-source enum and the
// target alignment mask used by pc_next_sel and pc_gen.
package pc_gen_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Which source won the redirect arbitration this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_TRAP = 2'd1,
    SRC_MRET = 2'd2,
    SRC_BR   = 2'd3
  } redir_src_e;

  // Low PC bits that are always cleared on a target load
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |(lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Purpose : combinational next-PC selection for pc_gen; fixed-priority
//           redirect arbitration (trap > mret > branch), halt request and
//           sequential advance. Latency: 0 (pure combinational).
// Ports   : i_state/i_pc current FSM state and PC; i_stall/i_fetch_ready
//           hold conditions; redirect requests and targets; o_next_pc,
//           o_src (winning redirect source), o_halt_go (enter HALT).
// Config  : PC_ALIGN_CHECK_EN adds o_misalign / o_misalign_addr.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INSTR_BYTES = 4
) (
  input  logic [1:0]      i_state,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_stall,
  input  logic            i_fetch_ready,
  input  logic            i_br_redirect,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_trap_req,
  input  logic [XLEN-1:0] i_trap_vector,
  input  logic            i_mret_req,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_halt_req,
  output logic [XLEN-1:0] o_next_pc,
  output redir_src_e      o_src,
  output logic            o_halt_go
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_misalign_addr
`endif
);

  localparam logic [XLEN-1:0] W_MASK = {{(XLEN-2){1'b1}}, ~ALIGN_MASK};

  redir_src_e      w_src;
  logic [XLEN-1:0] w_raw;

  // In HALT only a trap can redirect; RESET never redirects.
  always_comb begin
    w_src = SRC_NONE;
    if (i_state == ST_RUN) begin
      if (i_trap_req)         w_src = SRC_TRAP;
      else if (i_mret_req)    w_src = SRC_MRET;
      else if (i_br_redirect) w_src = SRC_BR;
    end else if (i_state == ST_HALT) begin
      if (i_trap_req)         w_src = SRC_TRAP;
    end
  end

  always_comb begin
    case (w_src)
      SRC_TRAP: w_raw = i_trap_vector;
      SRC_MRET: w_raw = i_mepc;
      SRC_BR:   w_raw = i_br_target;
      default:  w_raw = '0;
    endcase
  end

  always_comb begin
    o_next_pc = i_pc;
    o_halt_go = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    o_misalign      = 1'b0;
    o_misalign_addr = w_raw;
`endif
    if (w_src != SRC_NONE) begin
`ifdef PC_ALIGN_CHECK_EN
      // A misaligned branch/mret target is diverted to the trap handler.
      if ((w_src != SRC_TRAP) && is_misaligned(w_raw[1:0])) begin
        o_misalign = 1'b1;
        o_next_pc  = i_trap_vector & W_MASK;
      end else begin
        o_next_pc  = w_raw & W_MASK;
      end
`else
      o_next_pc = w_raw & W_MASK;
`endif
    end else if (i_state == ST_RUN) begin
      if (i_halt_req) begin
        o_halt_go = 1'b1;
      end else if (!i_stall && i_fetch_ready) begin
        // Natural modulo-2^XLEN wrap, no overflow flag.
        o_next_pc = i_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  assign o_src = w_src;

endmodule

// File: rtl/pc_gen.sv
// Purpose : fetch PC generator; FSM (RESET/RUN/HALT), PC register and
//           registered redirect flush. Updates appear one cycle after the
//           deciding edge; no input-to-output combinational path.
// Ports   : clk, rst (sync, active-low); stall/fetch_ready hold the PC
//           (valid stays high, address stable); br/trap/mret redirects;
//           halt_req/wake; pc_out, pc_valid, redirect_flush, halted.
// Config  : PC_ALIGN_CHECK_EN adds misalign_exc / misalign_addr.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            br_redirect,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mepc,
  input  logic            halt_req,
  input  logic            wake,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            redirect_flush,
  output logic            halted
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            r_flush;
  logic            w_taken;
  logic            w_halt_go;
  redir_src_e      w_src;
`ifdef PC_ALIGN_CHECK_EN
  logic            r_misalign_exc;
  logic [XLEN-1:0] r_misalign_addr;
  logic            w_misalign;
  logic [XLEN-1:0] w_misalign_addr;
`endif

  pc_next_sel #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_sel (
    .i_state       (r_state),
    .i_pc          (r_pc),
    .i_stall       (stall),
    .i_fetch_ready (fetch_ready),
    .i_br_redirect (br_redirect),
    .i_br_target   (br_target),
    .i_trap_req    (trap_req),
    .i_trap_vector (trap_vector),
    .i_mret_req    (mret_req),
    .i_mepc        (mepc),
    .i_halt_req    (halt_req),
    .o_next_pc     (w_next_pc),
    .o_src         (w_src),
    .o_halt_go     (w_halt_go)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .o_misalign      (w_misalign),
    .o_misalign_addr (w_misalign_addr)
`endif
  );

  assign w_taken = (w_src != SRC_NONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET: w_state_nxt = ST_RUN;
      ST_RUN:   if (w_halt_go) w_state_nxt = ST_HALT;
      ST_HALT:  if (w_taken || wake) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RESET;
      r_pc    <= RESET_VECTOR;
      r_flush <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      r_misalign_exc  <= 1'b0;
      r_misalign_addr <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_next_pc;
      r_flush <= w_taken;
`ifdef PC_ALIGN_CHECK_EN
      r_misalign_exc <= w_misalign;
      // Offending address is sticky until the next misaligned target.
      if (w_misalign) r_misalign_addr <= w_misalign_addr;
`endif
    end
  end

  assign pc_out         = r_pc;
  assign pc_valid       = (r_state == ST_RUN);
  assign halted         = (r_state == ST_HALT);
  assign redirect_flush = r_flush;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign_exc   = r_misalign_exc;
  assign misalign_addr  = r_misalign_addr;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen: each vector drives inputs before an
// edge and queues the outputs expected after it; a monitor compares.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_ready, br_redirect, trap_req, mret_req;
  logic        halt_req, wake;
  logic [31:0] br_target, trap_vector, mepc;
  logic [31:0] pc_out;
  logic        pc_valid, redirect_flush, halted;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_exc;
  logic [31:0] misalign_addr;
`endif

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .INSTR_BYTES  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .fetch_ready    (fetch_ready),
    .br_redirect    (br_redirect),
    .br_target      (br_target),
    .trap_req       (trap_req),
    .trap_vector    (trap_vector),
    .mret_req       (mret_req),
    .mepc           (mepc),
    .halt_req       (halt_req),
    .wake           (wake),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .redirect_flush (redirect_flush),
    .halted         (halted)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr)
`endif
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        v;
    logic        fl;
    logic        h;
    logic        mx;
    logic [31:0] ma;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          vec_id = 0;
  logic [31:0] exp_ma = 32'h0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", nm, id, act, exp);
    end
  endtask

  // Monitor: one expected entry per edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pc_out",         e.id, pc_out,                e.pc);
      chk("pc_valid",       e.id, {31'b0, pc_valid},       {31'b0, e.v});
      chk("redirect_flush", e.id, {31'b0, redirect_flush}, {31'b0, e.fl});
      chk("halted",         e.id, {31'b0, halted},         {31'b0, e.h});
`ifdef PC_ALIGN_CHECK_EN
      chk("misalign_exc",   e.id, {31'b0, misalign_exc},   {31'b0, e.mx});
      chk("misalign_addr",  e.id, misalign_addr,           e.ma);
`endif
    end
  end

  task automatic step(input logic r, s, f, b, input logic [31:0] bt,
                      input logic t, input logic [31:0] tv,
                      input logic m, input logic [31:0] mp,
                      input logic h, w,
                      input logic [31:0] epc, input logic ev, efl, eh, emx);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; fetch_ready = f; br_redirect = b; br_target = bt;
    trap_req = t; trap_vector = tv; mret_req = m; mepc = mp;
    halt_req = h; wake = w;
    vec_id++;
    e.id = vec_id; e.pc = epc; e.v = ev; e.fl = efl; e.h = eh;
    e.mx = emx; e.ma = exp_ma;
    sbq.push_back(e);
  endtask

  localparam logic [31:0] TV = 32'h0000_0100;

  initial begin
    rst = 1'b0; stall = 1'b0; fetch_ready = 1'b1; br_redirect = 1'b0;
    br_target = '0; trap_req = 1'b0; trap_vector = TV; mret_req = 1'b0;
    mepc = '0; halt_req = 1'b0; wake = 1'b0;

    // reset held 3 cycles, then release and sequential fetch
    for (int i = 0; i < 3; i++)
      step(0,0,1,0,0, 0,TV, 0,0, 0,0,  32'h0,   0,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h0,   1,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h4,   1,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h8,   1,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'hC,   1,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h10,  1,0,0,0);
    // stall holds with valid high
    for (int i = 0; i < 3; i++)
      step(1,1,1,0,0, 0,TV, 0,0, 0,0,  32'h10,  1,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h14,  1,0,0,0);
    // fetch_ready low holds likewise
    for (int i = 0; i < 3; i++)
      step(1,0,0,0,0, 0,TV, 0,0, 0,0,  32'h14,  1,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h18,  1,0,0,0);
    // trap beats branch and stall
    step(1,1,1,1,32'h200, 1,TV, 0,0, 0,0, 32'h100, 1,1,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h104, 1,0,0,0);
    // branch to misaligned target
`ifdef PC_ALIGN_CHECK_EN
    exp_ma = 32'h203;
    step(1,0,1,1,32'h203, 0,TV, 0,0, 0,0, 32'h100, 1,1,0,1);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h104, 1,0,0,0);
`else
    step(1,0,1,1,32'h203, 0,TV, 0,0, 0,0, 32'h200, 1,1,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h204, 1,0,0,0);
`endif
    step(1,0,1,1,32'h40, 0,TV, 0,0, 0,0, 32'h40,  1,1,0,0);
    // halt; branch/mret/stall/halt ignored; wake resumes without flush
    step(1,0,1,0,0, 0,TV, 0,0, 1,0,    32'h40,  0,0,1,0);
    step(1,0,1,1,32'h300, 0,TV, 0,0, 0,0, 32'h40, 0,0,1,0);
    step(1,1,1,0,0, 0,TV, 1,32'h500, 1,0, 32'h40, 0,0,1,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,1,    32'h40,  1,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h44,  1,0,0,0);
    // halt loses to a same-cycle branch
    step(1,0,1,1,32'h80, 0,TV, 0,0, 1,0, 32'h80,  1,1,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 1,0,    32'h80,  0,0,1,0);
    // leave HALT via trap (with flush)
    step(1,0,1,0,0, 1,TV, 0,0, 0,1,    32'h100, 1,1,0,0);
    // mret beats branch; then wrap at top of address space
    step(1,0,1,1,32'h200, 0,TV, 1,32'hFFFF_FFFC, 0,0, 32'hFFFF_FFFC, 1,1,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h0,   1,0,0,0);
    // back-to-back redirects give back-to-back flushes
    step(1,0,1,1,32'h600, 0,TV, 0,0, 0,0, 32'h600, 1,1,0,0);
    step(1,0,1,1,32'h700, 0,TV, 0,0, 0,0, 32'h700, 1,1,0,0);
    step(1,0,1,0,0, 1,32'h101, 0,0, 0,0, 32'h100, 1,1,0,0);
    step(1,1,1,0,0, 0,TV, 0,0, 0,0,    32'h100, 1,0,0,0);
    // reset overrides pending redirects
    exp_ma = 32'h0;
    step(0,0,1,1,32'h900, 1,TV, 0,0, 0,0, 32'h0, 0,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h0,   1,0,0,0);
    // reset overrides HALT
    step(1,0,1,0,0, 0,TV, 0,0, 1,0,    32'h0,   0,0,1,0);
    step(0,0,1,0,0, 0,TV, 0,0, 0,1,    32'h0,   0,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h0,   1,0,0,0);
    step(1,0,1,0,0, 0,TV, 0,0, 0,0,    32'h4,   1,0,0,0);

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
